// File: rtl/uut_result_packer.sv
// Measures UUT run time in clock cycles, then streams a framed record
// (header, count, result, XOR checksum) out over a valid/ready byte port.
module uut_result_packer #(
    parameter int OUTPUT_SIZE = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_meas,
    input  logic                   end_uut,
    input  logic [OUTPUT_SIZE-1:0] output_from_UUT,
    input  logic                   abort,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic                   overflow
);

    localparam int CB = CNT_WIDTH / 8;
    localparam int RB = OUTPUT_SIZE / 8;
    localparam int L  = 2 + CB + RB;
    localparam int IW = $clog2(L);
    localparam logic [IW-1:0] LAST = IW'(L - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_WIDTH-1:0]   cc_q, cc_d;
    logic                   ovf_q, ovf_d;
    logic [OUTPUT_SIZE-1:0] res_q, res_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [7:0]             chk_q, chk_d;

    logic [7:0]             rec_byte;
    logic [CNT_WIDTH-1:0]   cc_sh;
    logic [OUTPUT_SIZE-1:0] res_sh;
    logic                   xfer;
    int                     ii;

    // Record byte selected by index; checksum byte is the running XOR.
    always_comb begin
        rec_byte = 8'h00;
        cc_sh    = '0;
        res_sh   = '0;
        ii       = int'(idx_q);
        if (ii == 0) begin
            rec_byte = 8'hA5;
        end else if (ii <= CB) begin
            cc_sh    = cc_q >> (8 * (CB - ii));
            rec_byte = cc_sh[7:0];
        end else if (ii <= CB + RB) begin
            res_sh   = res_q >> (8 * (CB + RB - ii));
            rec_byte = res_sh[7:0];
        end else begin
            rec_byte = chk_q;
        end
    end

    assign xfer = (state_q == S_SEND) && byte_ready && !abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        cc_d    = cc_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_meas) begin
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (end_uut) begin
                        cc_d    = cnt_q;
                        ovf_d   = sat_q;
                        res_d   = output_from_UUT;
                        idx_d   = '0;
                        chk_d   = 8'h00;
                        state_d = S_SEND;
                    end else if (&cnt_q) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        chk_d = chk_q ^ rec_byte;
                        if (idx_q == LAST) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            cc_q    <= '0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            idx_q   <= '0;
            chk_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            cc_q    <= cc_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
        end
    end

    assign byte_out    = (state_q == S_SEND) ? rec_byte : 8'h00;
    assign byte_valid  = (state_q == S_SEND) && !abort;
    assign done        = (state_q == S_DONE) && !abort;
    assign busy        = (state_q != S_IDLE);
    assign cycle_count = cc_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_uut_result_packer.sv
// Randomized record checks against a byte-queue model, plus saturation,
// abort, reset and ignored-input scenarios.
module tb_uut_result_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_meas;
    logic        end_uut;
    logic [31:0] out_uut;
    logic        abort;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;
    logic [31:0] cycle_count;
    logic        overflow;

    logic        s_start;
    logic        s_end;
    logic [7:0]  s_out;
    logic        s_abort;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_ready;
    logic        s_busy;
    logic        s_done;
    logic [7:0]  s_cc;
    logic        s_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uut_result_packer #(.OUTPUT_SIZE(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_meas(start_meas), .end_uut(end_uut),
        .output_from_UUT(out_uut), .abort(abort), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
        .done(done), .cycle_count(cycle_count), .overflow(overflow)
    );

    uut_result_packer #(.OUTPUT_SIZE(8), .CNT_WIDTH(8)) dut_sat (
        .clk(clk), .rst(rst), .start_meas(s_start), .end_uut(s_end),
        .output_from_UUT(s_out), .abort(s_abort), .byte_out(s_byte),
        .byte_valid(s_valid), .byte_ready(s_ready), .busy(s_busy),
        .done(s_done), .cycle_count(s_cc), .overflow(s_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_rec(input logic [31:0] cnt,
                                      input logic [31:0] res,
                                      output logic [7:0] q[$]);
        logic [7:0] x;
        q = {};
        q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) q.push_back(8'((cnt >> (8 * i)) & 32'hFF));
        for (int i = 3; i >= 0; i--) q.push_back(8'((res >> (8 * i)) & 32'hFF));
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(x);
    endfunction

    task automatic run_rec(input int n0, input logic [31:0] res,
                           input int rmode, input bit poke);
        logic [7:0] expq[$];
        logic [7:0] got[$];
        logic [7:0] prev_b;
        bit pend, tog, stall_used, poked;
        int stall, cyc;
        build_rec(32'(n0), res, expq);
        start_meas = 1'b1;
        end_uut = (n0 == 0);
        out_uut = res;
        tick();
        start_meas = 1'b0;
        repeat (n0) begin
            end_uut = 1'b0;
            out_uut = $urandom;
            tick();
        end
        end_uut = 1'b1;
        out_uut = res;
        tick();
        end_uut = 1'b0;
        out_uut = $urandom;
        chk("first_valid", byte_valid, 1);
        chk("cycle_count", cycle_count, 32'(n0));
        chk("overflow", overflow, 0);
        pend = 0; tog = 1; stall_used = 0; poked = 0; stall = 0; cyc = 0;
        prev_b = 8'h00;
        while (got.size() < 10 && cyc < 400) begin
            if (rmode == 0) begin
                byte_ready = 1'b1;
            end else if (rmode == 1) begin
                if (got.size() == 3 && !stall_used) begin
                    stall_used = 1;
                    stall = 7;
                end
                if (stall > 0) begin
                    byte_ready = 1'b0;
                    stall--;
                end else begin
                    byte_ready = tog;
                    tog = !tog;
                end
            end else begin
                byte_ready = 1'($urandom_range(0, 1));
            end
            if (poke && got.size() == 5 && !poked) begin
                start_meas = 1'b1;
                poked = 1;
            end
            #1;
            if (pend) begin
                chk("hold_valid", byte_valid, 1);
                chk("hold_byte", byte_out, prev_b);
            end
            if (byte_valid && byte_ready) got.push_back(byte_out);
            pend = byte_valid && !byte_ready;
            prev_b = byte_out;
            tick();
            start_meas = 1'b0;
            cyc++;
        end
        byte_ready = 1'b0;
        chk("rec_len", 64'(got.size()), 10);
        for (int i = 0; i < 10; i++)
            if (i < got.size()) chk($sformatf("byte%0d", i), got[i], expq[i]);
        chk("done_valid", byte_valid, 0);
        chk("done_pulse", done, 1);
        tick();
        chk("done_end", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        logic [7:0] got[$];
        int cyc;
        rst = 1'b1; start_meas = 0; end_uut = 0; out_uut = 0; abort = 0;
        byte_ready = 0;
        s_start = 0; s_end = 0; s_out = 0; s_abort = 0; s_ready = 0;
        tick(); tick();
        chk("rst_byte", byte_out, 0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cc", cycle_count, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        run_rec(4, 32'hDEADBEEF, 0, 0);
        run_rec(0, $urandom, 0, 0);
        run_rec(9, $urandom, 1, 0);
        run_rec(6, $urandom, 0, 1);

        end_uut = 1'b1;
        repeat (3) tick();
        chk("idle_end_busy", busy, 0);
        chk("idle_end_cc", cycle_count, 6);
        end_uut = 1'b0;

        for (int t = 0; t < 10; t++)
            run_rec($urandom_range(0, 40), $urandom, t % 3, (t % 4) == 1);

        // abort after four bytes have gone out
        start_meas = 1'b1;
        tick();
        start_meas = 1'b0;
        repeat (3) tick();
        end_uut = 1'b1;
        out_uut = 32'h12345678;
        tick();
        end_uut = 1'b0;
        got = {};
        cyc = 0;
        while (got.size() < 4 && cyc < 50) begin
            byte_ready = 1'b1;
            #1;
            if (byte_valid) got.push_back(byte_out);
            tick();
            cyc++;
        end
        chk("abort_pre", 64'(got.size()), 4);
        abort = 1'b1;
        #1;
        chk("abort_valid", byte_valid, 0);
        chk("abort_done", done, 0);
        tick();
        abort = 1'b0;
        byte_ready = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid2", byte_valid, 0);
        chk("abort_cc", cycle_count, 3);
        chk("abort_ovf", overflow, 0);
        repeat (4) begin
            tick();
            chk("abort_nodone", done, 0);
        end

        // reset mid-measurement
        start_meas = 1'b1;
        tick();
        start_meas = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_byte", byte_out, 0);
        chk("mrst_valid", byte_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_cc", cycle_count, 0);
        chk("mrst_ovf", overflow, 0);
        run_rec(7, $urandom, 2, 0);

        // saturation on the 8-bit counter instance
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (300) tick();
        s_end = 1'b1;
        s_out = 8'h3C;
        tick();
        s_end = 1'b0;
        chk("sat_cc", s_cc, 8'hFF);
        chk("sat_ovf", s_ovf, 1);
        got = {};
        cyc = 0;
        s_ready = 1'b1;
        while (got.size() < 4 && cyc < 50) begin
            #1;
            if (s_valid) got.push_back(s_byte);
            tick();
            cyc++;
        end
        s_ready = 1'b0;
        chk("sat_len", 64'(got.size()), 4);
        if (got.size() == 4) begin
            chk("sat_b0", got[0], 8'hA5);
            chk("sat_b1", got[1], 8'hFF);
            chk("sat_b2", got[2], 8'h3C);
            chk("sat_b3", got[3], 8'hA5 ^ 8'hFF ^ 8'h3C);
        end
        chk("sat_done", s_done, 1);
        tick();
        s_start = 1'b1;
        s_end = 1'b1;
        tick();
        s_start = 1'b0;
        chk("sat_clr_ovf", s_ovf, 0);
        chk("sat_cc_hold", s_cc, 8'hFF);
        tick();
        s_end = 1'b0;
        chk("sat_cc_zero", s_cc, 0);
        s_ready = 1'b1;
        repeat (8) tick();
        s_ready = 1'b0;
        chk("sat_idle", s_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
